pipeline_ctrl: RTL
==================

# pipeline_ctrl

Hazard and sequencing controller for the 5-stage core (IF/ID/EX/MEM/WB). It consumes the ID-stage register and memory enables (`rs1_re`, `rs2_re`, `rd_we`, `mem_re`) and tracks every in-flight instruction in shadow stage records. From those records it drives stall, flush and bubble signals plus EX-stage operand-forward selects. It also counts stall cycles for performance visibility.

## Interface
- `REG_AW`, 5: register address width
- `CNT_W`, 32: stall counter width
- `clk` in 1: core clock
- `rst_n` in 1: reset, asynchronous, active-low
- `id_valid` in 1: ID holds a real instruction
- `id_rs1_addr`, `id_rs2_addr` in REG_AW: ID source registers
- `id_rs1_re`, `id_rs2_re`, `id_rd_we`, `id_mem_re` in 1: ID-stage enables
- `id_rd_addr` in REG_AW: ID destination register
- `ex_jump` in 1: taken branch or jump resolved in EX; held by upstream while frozen
- `mem_busy` in 1: data memory not ready; the whole pipe must freeze
- `stall_if`, `stall_id` out 1: hold PC and the IF/ID register
- `stall_ex`, `stall_mem` out 1: hold the ID/EX and EX/MEM registers
- `flush_id` out 1: IF/ID loads a bubble
- `flush_ex` out 1: ID/EX loads a bubble
- `fwd_rs1_sel`, `fwd_rs2_sel` out 2: EX operand source; 00 regfile, 01 EX/MEM result, 10 MEM/WB result
- `stall_cnt` out CNT_W: count of cycles with `stall_id`=1

## Operation
- **Shadow records** (registered):
  - EX record: {v, rs1, rs2, rs1_re, rs2_re, rd, rd_we, mem_re}
  - MEM record: {v, rd, rd_we, mem_re}
  - WB record: {v, rd, rd_we}
- **Load-use (LU):** asserted when all of the following hold:
  - `id_valid`, EX.v, EX.mem_re, EX.rd_we, and EX.rd≠0
  - (`id_rs1_re` and `id_rs1_addr`==EX.rd) or (`id_rs2_re` and `id_rs2_addr`==EX.rd)
- **Priority per cycle:** `mem_busy` > `ex_jump` > LU > normal.
  - **busy:** all four stall outputs are 1 and both flushes are 0. EX and MEM records hold. WB.v←0, because the regfile is write-through and its value is already visible.
  - **jump:** `flush_id`=`flush_ex`=1. EX.v←0. MEM←EX and WB←MEM as normal. No stall, even if LU is also true.
  - **LU:** `stall_if`=`stall_id`=1 and `flush_ex`=1. EX.v←0 (bubble). MEM←EX and WB←MEM.
  - **normal:** EX←ID fields, with v=`id_valid`. MEM←EX and WB←MEM. All control outputs are 0.
- **Forwarding:** combinational from the records, evaluated independently for rs1 and rs2.
  - 01 when MEM.v, MEM.rd_we, !MEM.mem_re, MEM.rd≠0, EX.rsN_re, and MEM.rd==EX.rsN.
  - Otherwise 10 when WB.v, WB.rd_we, WB.rd≠0, EX.rsN_re, and WB.rd==EX.rsN.
  - Otherwise 00.
  - MEM takes priority over WB because it holds the younger result.
  - x0 is never forwarded. When EX.v=0 the selects are 00.
- **stall_cnt:** +1 in every cycle where `stall_id`=1 (busy or LU). It wraps modulo 2^CNT_W with no saturation.

## Timing
- Reset values: all record valid bits 0 and all fields 0. `stall_cnt`=0. All stall, flush and fwd outputs 0.
- Stall, flush and fwd outputs are combinational from the current inputs and records. Records and the counter update on the rising edge of `clk`.
- LU costs exactly one bubble. In the following cycle the load is in MEM and the consumer is still in ID. One cycle later the consumer is in EX, the load is in WB, and the select is 10.
- `ex_jump` during `mem_busy` is deferred. It takes effect in the first cycle with `mem_busy`=0.
- `rst_n` deasserted mid-stall clears all records immediately, with no pending bubble or jump.
- `id_valid`=0 suppresses LU regardless of the other ID fields.

## Structure
- Shared defines header holds:
  - `On`/`Off`
  - `REG_ADDR_WIDTH`
  - `FWD_RF`=2'b00, `FWD_EXMEM`=2'b01, `FWD_MEMWB`=2'b10
- Sub-module `fwd_sel`: combinational, one operand per instance, instantiated twice (rs1 and rs2).
- Top level holds the records, priority logic and counter. Target size is about 150–220 lines.

## Test plan
- `lw x5` in EX (mem_re, rd=5) with `add x6,x5,x7` in ID (rs1_re, rs1=5) -> `stall_if`=`stall_id`=`flush_ex`=1 for one cycle. Two cycles later the add is in EX with `fwd_rs1_sel`=10. `stall_cnt` 0->1.
- `add x3` in MEM and `sub x3` in WB, EX reads x3 on rs2 -> `fwd_rs2_sel`=01. If MEM.rd=4 instead -> 10.
- Producer rd=0 in MEM and WB, EX reads x0 -> both selects 00. LU with EX.rd=0 -> no stall.
- `ex_jump`=1 while LU is also true -> `flush_id`=`flush_ex`=1, stalls 0, counter unchanged, next EX.v=0.
- `mem_busy` held for 3 cycles while `ex_jump`=1 -> 3 cycles of all stalls=1 with flushes 0, `stall_cnt`+=3. In the 4th cycle the flushes assert.
- `stall_cnt` preset near 2^CNT_W-1 (CNT_W=4 build, value 15) plus one LU cycle -> 0. Assert `rst_n`=0 during busy -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/pipeline_ctrl_pkg.sv
// Purpose: shared constants and types for the 5-stage pipeline hazard controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package pipeline_ctrl_pkg;

    localparam logic ON  = 1'b1;
    localparam logic OFF = 1'b0;

    localparam int REG_ADDR_WIDTH = 5;

    // EX operand source select encodings
    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    // Per-cycle controller action, strongest first: busy > jump > load-use > normal
    typedef enum logic [1:0] {
        MODE_NORMAL = 2'd0,
        MODE_LU     = 2'd1,
        MODE_JUMP   = 2'd2,
        MODE_BUSY   = 2'd3
    } ctrl_mode_e;

endpackage

// File: rtl/pipeline_ctrl_fwd_sel.sv
// Purpose: EX operand forward select for one source operand.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of the shadow records.
//
// Ports: ex_v/ex_rs_re/ex_rs describe the EX consumer; mem_* and wb_* describe
// the producers in MEM and WB; sel is the FWD_* source code.
module pipeline_ctrl_fwd_sel
    import pipeline_ctrl_pkg::*;
#(
    parameter int AW = REG_ADDR_WIDTH
) (
    input  logic          ex_v,
    input  logic          ex_rs_re,
    input  logic [AW-1:0] ex_rs,
    input  logic          mem_v,
    input  logic          mem_rd_we,
    input  logic          mem_mem_re,
    input  logic [AW-1:0] mem_rd,
    input  logic          wb_v,
    input  logic          wb_rd_we,
    input  logic [AW-1:0] wb_rd,
    output logic [1:0]    sel
);

    logic use_rs;
    logic mem_hit;
    logic wb_hit;

    always_comb begin
        // Checking the consumer's address against x0 is equivalent to checking
        // the producer's rd, since a hit requires them to be equal.
        use_rs  = ex_v && ex_rs_re && (ex_rs != '0);
        // A load in MEM has no data yet; that case is covered by the LU bubble.
        mem_hit = mem_v && mem_rd_we && !mem_mem_re && (mem_rd == ex_rs);
        wb_hit  = wb_v && wb_rd_we && (wb_rd == ex_rs);

        sel = FWD_RF;
        if (use_rs && mem_hit) begin
            sel = FWD_EXMEM;   // younger result wins
        end else if (use_rs && wb_hit) begin
            sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Purpose: hazard/sequencing controller: stalls, flushes, EX forward selects, stall counter.
// Latency: control outputs combinational; shadow records and stall_cnt update on the clk edge.
// Backpressure: mem_busy freezes the whole pipe; load-use holds IF/ID and bubbles EX.
//
// Ports: ID-stage fields (id_*), ex_jump and mem_busy in; stall_if/id/ex/mem,
// flush_id/ex, fwd_rs1_sel/fwd_rs2_sel and stall_cnt out.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int REG_AW = REG_ADDR_WIDTH,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs1_addr,
    input  logic [REG_AW-1:0] id_rs2_addr,
    input  logic              id_rs1_re,
    input  logic              id_rs2_re,
    input  logic              id_rd_we,
    input  logic              id_mem_re,
    input  logic [REG_AW-1:0] id_rd_addr,
    input  logic              ex_jump,
    input  logic              mem_busy,
    output logic              stall_if,
    output logic              stall_id,
    output logic              stall_ex,
    output logic              stall_mem,
    output logic              flush_id,
    output logic              flush_ex,
    output logic [1:0]        fwd_rs1_sel,
    output logic [1:0]        fwd_rs2_sel,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef struct packed {
        logic              v;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic              rs1_re;
        logic              rs2_re;
        logic [REG_AW-1:0] rd;
        logic              rd_we;
        logic              mem_re;
    } ex_rec_t;

    typedef struct packed {
        logic              v;
        logic [REG_AW-1:0] rd;
        logic              rd_we;
        logic              mem_re;
    } mem_rec_t;

    typedef struct packed {
        logic              v;
        logic [REG_AW-1:0] rd;
        logic              rd_we;
    } wb_rec_t;

    ex_rec_t    ex_q,  ex_d;
    mem_rec_t   mem_q, mem_d;
    wb_rec_t    wb_q,  wb_d;
    ctrl_mode_e mode;
    logic       rs1_hit;
    logic       rs2_hit;
    logic       lu_hit;

    // Load-use: a load in EX writes a register the ID instruction reads.
    always_comb begin
        rs1_hit = id_rs1_re && (id_rs1_addr == ex_q.rd);
        rs2_hit = id_rs2_re && (id_rs2_addr == ex_q.rd);
        lu_hit  = id_valid && ex_q.v && ex_q.mem_re && ex_q.rd_we &&
                  (ex_q.rd != '0) && (rs1_hit || rs2_hit);
    end

    // While in reset every control output is forced quiet, even with mem_busy
    // or ex_jump still asserted by upstream.
    always_comb begin
        mode = MODE_NORMAL;
        if (rst_n) begin
            if (mem_busy) begin
                mode = MODE_BUSY;
            end else if (ex_jump) begin
                mode = MODE_JUMP;
            end else if (lu_hit) begin
                mode = MODE_LU;
            end
        end
    end

    // Control outputs and next shadow records
    always_comb begin
        stall_if  = OFF;
        stall_id  = OFF;
        stall_ex  = OFF;
        stall_mem = OFF;
        flush_id  = OFF;
        flush_ex  = OFF;

        ex_d.v      = id_valid;
        ex_d.rs1    = id_rs1_addr;
        ex_d.rs2    = id_rs2_addr;
        ex_d.rs1_re = id_rs1_re;
        ex_d.rs2_re = id_rs2_re;
        ex_d.rd     = id_rd_addr;
        ex_d.rd_we  = id_rd_we;
        ex_d.mem_re = id_mem_re;

        mem_d.v      = ex_q.v;
        mem_d.rd     = ex_q.rd;
        mem_d.rd_we  = ex_q.rd_we;
        mem_d.mem_re = ex_q.mem_re;

        wb_d.v     = mem_q.v;
        wb_d.rd    = mem_q.rd;
        wb_d.rd_we = mem_q.rd_we;

        unique case (mode)
            MODE_BUSY: begin
                stall_if  = ON;
                stall_id  = ON;
                stall_ex  = ON;
                stall_mem = ON;
                ex_d      = ex_q;
                mem_d     = mem_q;
                // The regfile is write-through, so the WB result is already
                // readable and must not be forwarded a second time.
                wb_d      = wb_q;
                wb_d.v    = OFF;
            end
            MODE_JUMP: begin
                flush_id = ON;
                flush_ex = ON;
                ex_d     = '0;
            end
            MODE_LU: begin
                stall_if = ON;
                stall_id = ON;
                flush_ex = ON;
                ex_d     = '0;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q      <= '0;
            mem_q     <= '0;
            wb_q      <= '0;
            stall_cnt <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
            if (stall_id) begin
                stall_cnt <= stall_cnt + CNT_W'(1);   // wraps, no saturation
            end
        end
    end

    pipeline_ctrl_fwd_sel #(.AW(REG_AW)) u_fwd_rs1 (
        .ex_v       (ex_q.v),
        .ex_rs_re   (ex_q.rs1_re),
        .ex_rs      (ex_q.rs1),
        .mem_v      (mem_q.v),
        .mem_rd_we  (mem_q.rd_we),
        .mem_mem_re (mem_q.mem_re),
        .mem_rd     (mem_q.rd),
        .wb_v       (wb_q.v),
        .wb_rd_we   (wb_q.rd_we),
        .wb_rd      (wb_q.rd),
        .sel        (fwd_rs1_sel)
    );

    pipeline_ctrl_fwd_sel #(.AW(REG_AW)) u_fwd_rs2 (
        .ex_v       (ex_q.v),
        .ex_rs_re   (ex_q.rs2_re),
        .ex_rs      (ex_q.rs2),
        .mem_v      (mem_q.v),
        .mem_rd_we  (mem_q.rd_we),
        .mem_mem_re (mem_q.mem_re),
        .mem_rd     (mem_q.rd),
        .wb_v       (wb_q.v),
        .wb_rd_we   (wb_q.rd_we),
        .wb_rd      (wb_q.rd),
        .sel        (fwd_rs2_sel)
    );

endmodule
